// File: rtl/bram_stream_reader.sv
// Read-initiator for one BRAM port: streams WordCount consecutive words from
// StartAddress onto a valid/ready interface through a credit-limited FIFO.
module bram_stream_reader #(
    parameter int unsigned AddrWidth  = 14,
    parameter int unsigned CountWidth = 16,
    parameter int unsigned FifoDepth  = 2
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    input  logic                  Start,
    input  logic [AddrWidth-1:0]  StartAddress,
    input  logic [CountWidth-1:0] WordCount,
    input  logic                  Abort,
    output logic                  Busy,
    output logic                  Done,
    output logic [31:0]           BramAddress,
    output logic                  BramClockEn,
    output logic                  BramWrite,
    output logic [31:0]           BramDataIn,
    input  logic [31:0]           BramDataOut,
    output logic [31:0]           StreamData,
    output logic                  StreamValid,
    input  logic                  StreamReady,
    output logic                  StreamLast
);
    localparam int unsigned PtrWidth = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam int unsigned CntWidth = $clog2(FifoDepth + 1);

    typedef enum logic [1:0] {Idle, Read, Drain} stateT;
    stateT state, nextState;

    logic [AddrWidth-1:0]  issueAddr;
    logic [CountWidth-1:0] issueLeft;
    logic [CountWidth-1:0] sendLeft;
    logic                  inFlight;
    logic [31:0]           fifoMem [FifoDepth];
    logic [PtrWidth-1:0]   wrPtr;
    logic [PtrWidth-1:0]   rdPtr;
    logic [CntWidth-1:0]   fifoCount;
    logic [CntWidth:0]     occupancy;
    logic                  pop;
    logic                  issue;
    logic                  startAccept;
    logic                  startEmpty;
    logic                  lastPop;
    logic                  doneQ;

    function automatic logic [PtrWidth-1:0] nextPtr(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(FifoDepth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    assign pop         = (fifoCount != '0) && StreamReady;
    assign startAccept = (state == Idle) && Start && !Abort && (WordCount != '0);
    assign startEmpty  = (state == Idle) && Start && !Abort && (WordCount == '0);
    assign lastPop     = (state == Drain) && pop && !Abort && (sendLeft == CountWidth'(1));
    // Words already owed to the FIFO: stored plus in flight, less the one leaving now.
    assign occupancy   = (CntWidth+1)'(fifoCount) + (CntWidth+1)'(inFlight) - (CntWidth+1)'(pop);

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) state <= Idle;
        else         state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            Idle:    if (startAccept) nextState = Read;
            Read:    if (Abort) nextState = Idle;
                     else if (issue && (issueLeft == CountWidth'(1))) nextState = Drain;
            Drain:   if (Abort || lastPop) nextState = Idle;
            default: nextState = Idle;
        endcase
    end

    always_comb begin
        Busy        = 1'b0;
        issue       = 1'b0;
        case (state)
            Read: begin
                Busy  = 1'b1;
                issue = !Abort && (issueLeft != '0) && (occupancy < (CntWidth+1)'(FifoDepth));
            end
            Drain:   Busy = 1'b1;
            default: ;
        endcase
        BramClockEn = issue;
    end

    // Address/count bookkeeping and FIFO pointers; Abort flushes everything in flight.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            issueAddr <= '0;
            issueLeft <= '0;
            sendLeft  <= '0;
            inFlight  <= 1'b0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
            doneQ     <= 1'b0;
        end else begin
            doneQ <= startEmpty || lastPop;
            if (Abort) begin
                issueLeft <= '0;
                sendLeft  <= '0;
                inFlight  <= 1'b0;
                wrPtr     <= '0;
                rdPtr     <= '0;
                fifoCount <= '0;
            end else begin
                inFlight <= issue;
                if (startAccept) begin
                    issueAddr <= StartAddress;
                    issueLeft <= WordCount;
                    sendLeft  <= WordCount;
                end
                if (issue) begin
                    issueAddr <= issueAddr + AddrWidth'(1);
                    issueLeft <= issueLeft - CountWidth'(1);
                end
                if (inFlight) wrPtr <= nextPtr(wrPtr);
                if (pop) begin
                    rdPtr    <= nextPtr(rdPtr);
                    sendLeft <= sendLeft - CountWidth'(1);
                end
                fifoCount <= fifoCount + CntWidth'(inFlight) - CntWidth'(pop);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (inFlight && !Abort) fifoMem[wrPtr] <= BramDataOut;
    end

    assign Done        = doneQ;
    assign BramAddress = 32'(issueAddr);
    assign BramWrite   = 1'b0;
    assign BramDataIn  = '0;
    assign StreamValid = (fifoCount != '0);
    assign StreamData  = fifoMem[rdPtr];
    assign StreamLast  = StreamValid && (sendLeft == CountWidth'(1));
endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader with a behavioural BRAM and stream monitor.
module tb_bram_stream_reader;
    logic        clk = 1'b0;
    logic        ResetN;
    logic        Start;
    logic [13:0] StartAddress;
    logic [15:0] WordCount;
    logic        Abort;
    logic        Busy;
    logic        Done;
    logic [31:0] BramAddress;
    logic        BramClockEn;
    logic        BramWrite;
    logic [31:0] BramDataIn;
    logic [31:0] BramDataOut;
    logic [31:0] StreamData;
    logic        StreamValid;
    logic        StreamReady;
    logic        StreamLast;

    bram_stream_reader #(.AddrWidth(14), .CountWidth(16), .FifoDepth(2)) dut (
        .Clock(clk), .ResetN(ResetN), .Start(Start), .StartAddress(StartAddress),
        .WordCount(WordCount), .Abort(Abort), .Busy(Busy), .Done(Done),
        .BramAddress(BramAddress), .BramClockEn(BramClockEn), .BramWrite(BramWrite),
        .BramDataIn(BramDataIn), .BramDataOut(BramDataOut), .StreamData(StreamData),
        .StreamValid(StreamValid), .StreamReady(StreamReady), .StreamLast(StreamLast)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [16384];
    always @(posedge clk) if (BramClockEn) BramDataOut <= mem[BramAddress[13:0]];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] beatData [$];
    logic        beatLast [$];
    int          beatCyc  [$];
    logic [31:0] addrLog  [$];
    int          doneCnt = 0;
    int          doneCyc = 0;
    int          outstanding = 0;
    int          maxOut = 0;
    logic        prevStall = 1'b0;
    logic        prevAbort = 1'b0;
    logic        prevLast = 1'b0;
    logic [31:0] prevData = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Records beats, issued addresses and Done pulses; checks stall stability and FIFO credit.
    always @(negedge clk) begin
        if (prevStall && ResetN && !prevAbort)
            check("stall_hold", 64'({StreamValid, StreamLast, StreamData}), 64'({1'b1, prevLast, prevData}));
        if (StreamValid && StreamReady) begin
            beatData.push_back(StreamData);
            beatLast.push_back(StreamLast);
            beatCyc.push_back(cyc);
        end
        if (BramClockEn) addrLog.push_back(BramAddress);
        if (Done) begin
            doneCnt++;
            doneCyc = cyc;
        end
        if (!ResetN || Abort) outstanding = 0;
        else outstanding = outstanding + int'(BramClockEn) - int'(StreamValid && StreamReady);
        if (outstanding > maxOut) maxOut = outstanding;
        prevStall = StreamValid && !StreamReady;
        prevAbort = Abort;
        prevLast  = StreamLast;
        prevData  = StreamData;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clearLogs();
        beatData.delete();
        beatLast.delete();
        beatCyc.delete();
        addrLog.delete();
        doneCnt = 0;
    endtask

    task automatic startCmd(input logic [13:0] addr, input logic [15:0] count);
        Start = 1'b1;
        StartAddress = addr;
        WordCount = count;
        tick(1);
        Start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int limit, input bit toggleReady);
        int k = 0;
        while (doneCnt == 0 && k < limit) begin
            if (toggleReady) StreamReady = (k % 4 == 0) || (k % 4 == 3);
            tick(1);
            k++;
        end
        StreamReady = 1'b1;
        check($sformatf("%s_done_seen", tag), 64'(doneCnt != 0), 64'd1);
    endtask

    task automatic checkBeats(input string tag, input int base, input int n, input int lastIdx);
        check($sformatf("%s_count", tag), 64'(beatData.size()), 64'(n));
        for (int i = 0; i < n && i < int'(beatData.size()); i++) begin
            check($sformatf("%s_data%0d", tag, i), 64'(beatData[i]),
                  64'(32'hA000_0000 + 32'((base + i) % 16384)));
            check($sformatf("%s_last%0d", tag, i), 64'(beatLast[i]), 64'(i == lastIdx));
        end
    endtask

    initial begin
        int e0;
        logic [31:0] expAddr [4];
        for (int i = 0; i < 16384; i++) mem[i] = 32'hA000_0000 + 32'(i);
        ResetN = 1'b1; Start = 1'b0; Abort = 1'b0; StreamReady = 1'b0;
        StartAddress = '0; WordCount = '0;
        #2 ResetN = 1'b0;
        tick(2);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_bram_en", 64'(BramClockEn), 64'd0);
        check("rst_bram_addr", 64'(BramAddress), 64'd0);
        check("rst_valid", 64'(StreamValid), 64'd0);
        check("rst_last", 64'(StreamLast), 64'd0);
        check("rst_bram_wr", 64'({BramWrite, BramDataIn}), 64'd0);
        ResetN = 1'b1;
        tick(2);

        // Basic read: 4 words from 16, latency and throughput
        clearLogs();
        StreamReady = 1'b1;
        e0 = cyc + 1;
        startCmd(14'd16, 16'd4);
        check("basic_busy", 64'(Busy), 64'd1);
        check("basic_first_en", 64'({BramClockEn, BramAddress}), 64'({1'b1, 32'd16}));
        waitDone("basic", 40, 1'b0);
        checkBeats("basic", 16, 4, 3);
        for (int i = 0; i < 4 && i < int'(beatCyc.size()); i++)
            check($sformatf("basic_cyc%0d", i), 64'(beatCyc[i] - e0), 64'(2 + i));
        check("basic_done_cyc", 64'(doneCyc - e0), 64'd6);
        check("basic_addr_n", 64'(addrLog.size()), 64'd4);
        for (int i = 0; i < 4 && i < int'(addrLog.size()); i++)
            check($sformatf("basic_addr%0d", i), 64'(addrLog[i]), 64'(16 + i));
        check("basic_idle", 64'(Busy), 64'd0);

        // Backpressure: ready pattern 1,0,0,1
        clearLogs();
        startCmd(14'd100, 16'd8);
        waitDone("bp", 200, 1'b1);
        checkBeats("bp", 100, 8, 7);
        check("bp_done_n", 64'(doneCnt), 64'd1);
        check("bp_addr_n", 64'(addrLog.size()), 64'd8);

        // Address wrap at 2^14
        clearLogs();
        startCmd(14'd16382, 16'd4);
        waitDone("wrap", 40, 1'b0);
        checkBeats("wrap", 16382, 4, 3);
        expAddr[0] = 32'd16382; expAddr[1] = 32'd16383; expAddr[2] = 32'd0; expAddr[3] = 32'd1;
        check("wrap_addr_n", 64'(addrLog.size()), 64'd4);
        for (int i = 0; i < 4 && i < int'(addrLog.size()); i++)
            check($sformatf("wrap_addr%0d", i), 64'(addrLog[i]), 64'(expAddr[i]));

        // Zero count: Done next cycle, nothing else
        tick(1);
        clearLogs();
        startCmd(14'd8, 16'd0);
        check("zero_done", 64'({Done, Busy, BramClockEn}), 64'({1'b1, 1'b0, 1'b0}));
        tick(3);
        check("zero_beats", 64'(beatData.size() + addrLog.size()), 64'd0);
        check("zero_done_n", 64'(doneCnt), 64'd1);

        // Start accepted in the Done cycle
        clearLogs();
        startCmd(14'd5, 16'd1);
        tick(3);
        check("bb_done", 64'(Done), 64'd1);
        checkBeats("bb_first", 5, 1, 0);
        Start = 1'b1; StartAddress = 14'd7; WordCount = 16'd1;
        tick(1);
        Start = 1'b0;
        clearLogs();
        check("bb_accept", 64'({Busy, BramClockEn, BramAddress}), 64'({1'b1, 1'b1, 32'd7}));
        waitDone("bb", 40, 1'b0);
        checkBeats("bb_second", 7, 1, 0);

        // Abort after 10 beats, then a fresh transfer
        tick(1);
        clearLogs();
        startCmd(14'd200, 16'd100);
        for (int k = 0; k < 60 && beatData.size() < 10; k++) tick(1);
        check("abort_pre_beats", 64'(beatData.size()), 64'd10);
        Abort = 1'b1;
        tick(1);
        Abort = 1'b0;
        check("abort_after", 64'({StreamValid, Busy, BramClockEn}), 64'd0);
        tick(4);
        checkBeats("abort", 200, 11, -1);
        check("abort_no_done", 64'(doneCnt), 64'd0);
        clearLogs();
        startCmd(14'd0, 16'd2);
        waitDone("post_abort", 40, 1'b0);
        checkBeats("post_abort", 0, 2, 1);

        // Start together with Abort in IDLE is ignored
        tick(1);
        clearLogs();
        Abort = 1'b1;
        startCmd(14'd50, 16'd3);
        Abort = 1'b0;
        check("sa_busy", 64'({Busy, Done}), 64'd0);
        tick(4);
        check("sa_quiet", 64'(beatData.size() + addrLog.size() + doneCnt), 64'd0);

        // Second Start while Busy has no effect
        clearLogs();
        startCmd(14'd40, 16'd3);
        Start = 1'b1; StartAddress = 14'd0; WordCount = 16'd9;
        tick(1);
        Start = 1'b0;
        waitDone("busy_start", 40, 1'b0);
        tick(3);
        checkBeats("busy_start", 40, 3, 2);
        check("busy_start_addr_n", 64'(addrLog.size()), 64'd3);
        check("busy_start_done_n", 64'({doneCnt[7:0], Busy}), 64'({8'd1, 1'b0}));

        // Asynchronous reset during READ
        clearLogs();
        startCmd(14'd300, 16'd20);
        tick(3);
        check("mid_reading", 64'(BramClockEn), 64'd1);
        #2 ResetN = 1'b0;
        #1;
        check("arst_outputs", 64'({Busy, Done, BramClockEn, StreamValid, StreamLast}), 64'd0);
        check("arst_addr", 64'(BramAddress), 64'd0);
        tick(2);
        ResetN = 1'b1;
        clearLogs();
        tick(5);
        check("arst_idle", 64'(beatData.size() + addrLog.size() + doneCnt + int'(Busy)), 64'd0);
        startCmd(14'd2, 16'd2);
        waitDone("post_rst", 40, 1'b0);
        checkBeats("post_rst", 2, 2, 1);

        check("fifo_bound", 64'(maxOut <= 2), 64'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
